// File: rtl/bank_isu_sched.sv
// Bank instruction scheduler: in-order issue queue from HTU to SC with per-channel ROB tags,
// set/way linefill hazard tracking, a one-entry BIU refill buffer and per-channel XBAR credits.
module bank_isu_sched #(
  parameter int SETS     = 8,
  parameter int WAYS     = 8,
  parameter int CH_NUM   = 3,
  parameter int IQ_DEPTH = 16,
  parameter int ROB_W    = 3,
  parameter int CRD_MAX  = 4,
  parameter int DATA_W   = 256,
  localparam int SET_W   = $clog2(SETS),
  localparam int WAY_W   = $clog2(WAYS),
  localparam int CH_W    = $clog2(CH_NUM),
  localparam int SWO_W   = SET_W + WAY_W + 1,
  localparam int RID_W   = SET_W + WAY_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                htu_isu_linefill_valid_i,
  input  logic [SET_W-1:0]    htu_isu_linefill_set_i,
  input  logic [WAY_W-1:0]    htu_isu_linefill_way_i,
  input  logic                htu_isu_valid_i,
  output logic                htu_isu_allowIn_o,
  input  logic [CH_W-1:0]     htu_isu_ch_id_i,
  input  logic [1:0]          htu_isu_opcode_i,
  input  logic [SWO_W-1:0]    htu_isu_set_way_offset_i,
  input  logic [7:0]          htu_isu_wbuffer_id_i,
  input  logic [1:0]          htu_isu_cacheline_offset0_state_i,
  input  logic [1:0]          htu_isu_cacheline_offset1_state_i,
  input  logic                biu_isu_rdata_valid_i,
  output logic                biu_isu_rdata_ready_o,
  input  logic [DATA_W-1:0]   biu_isu_rdata_i,
  input  logic [RID_W-1:0]    biu_isu_rid_i,
  output logic                isu_sc_valid_o,
  input  logic                isu_sc_ready_i,
  output logic [CH_W-1:0]     isu_sc_channel_id_o,
  output logic [2:0]          isu_sc_opcode_o,
  output logic [SWO_W-1:0]    isu_sc_set_way_offset_o,
  output logic [7:0]          isu_sc_wbuffer_id_o,
  output logic [ROB_W-1:0]    isu_sc_xbar_rob_num_o,
  output logic [1:0]          isu_sc_cacheline_dirty_offset0_o,
  output logic [1:0]          isu_sc_cacheline_dirty_offset1_o,
  output logic [DATA_W/2-1:0] isu_sc_linefill_data_offset0_o,
  output logic [DATA_W/2-1:0] isu_sc_linefill_data_offset1_o,
  input  logic [CH_NUM-1:0]   xbar_isu_crd_rtn_i
);
  localparam int IQ_AW = $clog2(IQ_DEPTH);
  localparam int CRD_W = $clog2(CRD_MAX + 1);
  localparam int HALF  = DATA_W / 2;
  localparam logic [1:0] OP_LF = 2'b10;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [1:0]       op;
    logic [SWO_W-1:0] swo;
    logic [7:0]       wbid;
    logic [1:0]       st0;
    logic [1:0]       st1;
    logic [ROB_W-1:0] rob;
  } iq_ent_t;

  iq_ent_t                          iq_q [IQ_DEPTH];
  logic [IQ_AW-1:0]                 wr_q, rd_q;
  logic [IQ_AW:0]                   cnt_q, cnt_d;
  logic [CH_NUM-1:0][ROB_W-1:0]     rob_q, rob_d;
  logic [CH_NUM-1:0][CRD_W-1:0]     crd_q, crd_d;
  logic [SETS-1:0][WAYS-1:0]        infl_q, infl_d;
  logic                             buf_v_q;
  logic [RID_W-1:0]                 buf_rid_q;
  logic [DATA_W-1:0]                buf_data_q;

  iq_ent_t          head, new_ent;
  logic [SET_W-1:0] head_set;
  logic [WAY_W-1:0] head_way;
  logic             empty, push, pop, head_lf, buf_hit, lf_fire, fill;

  assign empty    = (cnt_q == '0);
  assign head     = iq_q[rd_q];
  assign head_set = head.swo[SWO_W-1 -: SET_W];
  assign head_way = head.swo[WAY_W:1];
  assign head_lf  = (head.op == OP_LF);
  assign buf_hit  = buf_v_q && (buf_rid_q == {head_set, head_way});

  assign htu_isu_allowIn_o     = (cnt_q != (IQ_AW+1)'(IQ_DEPTH));
  assign biu_isu_rdata_ready_o = ~buf_v_q;
  assign push    = htu_isu_valid_i & htu_isu_allowIn_o;
  assign fill    = biu_isu_rdata_valid_i & biu_isu_rdata_ready_o;
  assign isu_sc_valid_o = !empty && (crd_q[head.ch] != '0) &&
                          (head_lf ? buf_hit : !infl_q[head_set][head_way]);
  assign pop     = isu_sc_valid_o & isu_sc_ready_i;
  assign lf_fire = pop & head_lf;

  assign new_ent = '{ch: htu_isu_ch_id_i, op: htu_isu_opcode_i, swo: htu_isu_set_way_offset_i,
                     wbid: htu_isu_wbuffer_id_i, st0: htu_isu_cacheline_offset0_state_i,
                     st1: htu_isu_cacheline_offset1_state_i, rob: rob_q[htu_isu_ch_id_i]};

  // Output fields are forced to zero while the queue is empty so reset shows a clean bus.
  always_comb begin
    isu_sc_channel_id_o              = '0;
    isu_sc_opcode_o                  = '0;
    isu_sc_set_way_offset_o          = '0;
    isu_sc_wbuffer_id_o              = '0;
    isu_sc_xbar_rob_num_o            = '0;
    isu_sc_cacheline_dirty_offset0_o = '0;
    isu_sc_cacheline_dirty_offset1_o = '0;
    isu_sc_linefill_data_offset0_o   = '0;
    isu_sc_linefill_data_offset1_o   = '0;
    if (!empty) begin
      isu_sc_channel_id_o              = head.ch;
      isu_sc_opcode_o                  = {1'b0, head.op};
      isu_sc_set_way_offset_o          = head.swo;
      isu_sc_wbuffer_id_o              = head.wbid;
      isu_sc_xbar_rob_num_o            = head.rob;
      isu_sc_cacheline_dirty_offset0_o = head.st0;
      isu_sc_cacheline_dirty_offset1_o = head.st1;
      if (head_lf && buf_v_q) begin
        isu_sc_linefill_data_offset0_o = buf_data_q[HALF-1:0];
        isu_sc_linefill_data_offset1_o = buf_data_q[DATA_W-1:HALF];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    for (int c = 0; c < CH_NUM; c++) begin
      rob_d[c] = rob_q[c];
      crd_d[c] = crd_q[c];
      if (push && htu_isu_ch_id_i == CH_W'(c)) rob_d[c] = rob_q[c] + 1'b1;
      // Issue and return on the same channel cancel; returns saturate at CRD_MAX.
      case ({xbar_isu_crd_rtn_i[c], pop && head.ch == CH_W'(c)})
        2'b10:   if (crd_q[c] != CRD_W'(CRD_MAX)) crd_d[c] = crd_q[c] + 1'b1;
        2'b01:   crd_d[c] = crd_q[c] - 1'b1;
        default: crd_d[c] = crd_q[c];
      endcase
    end
    // Clear first so a same-cycle allocation of the same bit wins.
    infl_d = infl_q;
    if (lf_fire) infl_d[head_set][head_way] = 1'b0;
    if (htu_isu_linefill_valid_i) infl_d[htu_isu_linefill_set_i][htu_isu_linefill_way_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rob_q   <= '0;
      for (int c = 0; c < CH_NUM; c++) crd_q[c] <= CRD_W'(CRD_MAX);
      infl_q  <= '0;
      buf_v_q <= 1'b0;
      buf_rid_q  <= '0;
      buf_data_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_d;
      rob_q  <= rob_d;
      crd_q  <= crd_d;
      infl_q <= infl_d;
      if (fill) begin
        buf_v_q    <= 1'b1;
        buf_rid_q  <= biu_isu_rid_i;
        buf_data_q <= biu_isu_rdata_i;
      end else if (lf_fire) begin
        buf_v_q    <= 1'b0;
      end
    end
  end

  // Queue storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) iq_q[wr_q] <= new_ent;
  end
endmodule
